// File: rtl/timeout_display.sv
// Captures the upstream timer count, converts it to four BCD digits (saturated at 9999)
// and time-multiplexes them onto an active-low 7-segment display. Optional: LEADING_ZERO_BLANK_EN.
module timeout_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sign_enable,
  input  logic [31:0] sign_timeout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

  state_e        state_q, state_d;
  logic          sen_q;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, done_q;
  logic [15:0]   dig_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [15:0]   adj;
  logic [3:0]    cur;
  logic          blank;
  logic          rise;

  assign rise = sign_enable & ~sen_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    adj     = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    case (state_q)
      IDLE: if (rise) begin
        if (sign_timeout > 32'd9999) begin
          bin_d = 14'd9999;
          ovf_d = 1'b1;
        end else begin
          bin_d = sign_timeout[13:0];
          ovf_d = 1'b0;
        end
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        bcd_d = {adj[14:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Display path works off the committed digits only, never the conversion registers.
  always_comb begin
    cur   = dig_q[{idx_q, 2'b00} +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1:    blank = (dig_q[15:4]  == 12'd0);
      2'd2:    blank = (dig_q[15:8]  == 8'd0);
      2'd3:    blank = (dig_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`endif
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (sign_enable) begin
      an_d = ~(4'b0001 << idx_q);
      if (!blank) begin
        case (cur)
          4'd0:    seg_d = 7'b1000000;
          4'd1:    seg_d = 7'b1111001;
          4'd2:    seg_d = 7'b0100100;
          4'd3:    seg_d = 7'b0110000;
          4'd4:    seg_d = 7'b0011001;
          4'd5:    seg_d = 7'b0010010;
          4'd6:    seg_d = 7'b0000010;
          4'd7:    seg_d = 7'b1111000;
          4'd8:    seg_d = 7'b0000000;
          4'd9:    seg_d = 7'b0010000;
          default: seg_d = 7'b1111111;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sen_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      sen_q   <= sign_enable;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      // One-cycle lag on busy/commit places the digit update at the edge after DONE.
      busy_q  <= (state_q != IDLE);
      done_q  <= (state_q == DONE);
      if (done_q) dig_q <= bcd_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_timeout_display.sv
// Directed bench for timeout_display (SCAN_DIV=4): capture timing, saturation,
// ignored re-trigger, scanning order, blanking and reset abort.
module tb_timeout_display;

  logic        clk;
  logic        reset;
  logic        sign_enable;
  logic [31:0] sign_timeout;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] m_presc, m_idx;
  logic [3:0] exp_an;

  timeout_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .sign_enable(sign_enable), .sign_timeout(sign_timeout),
    .seg(seg), .an(an), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected anode pattern: scan index advances every 4 cycles, output registered.
  always @(posedge clk) begin
    if (reset) begin
      m_presc <= 2'd0;
      m_idx   <= 2'd0;
      exp_an  <= 4'hF;
    end else begin
      exp_an  <= sign_enable ? ~(4'b0001 << m_idx) : 4'hF;
      m_presc <= m_presc + 2'd1;
      if (m_presc == 2'd3) m_idx <= m_idx + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int i);
    logic [3:0] d;
    d = bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (bcd >> (4*i)) == 16'd0) return 7'b1111111;
`endif
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check_display(input string tag, input logic [15:0] bcd, input int n);
    for (int c = 0; c < n; c++) begin
      tick(1);
      chk({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
      for (int i = 0; i < 4; i++)
        if (exp_an == ~(4'b0001 << i))
          chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(bcd, i)});
    end
  endtask

  // Drives a fresh capture (edge T) and runs to just past the digit commit.
  task automatic capture(input logic [31:0] v);
    sign_enable = 1'b0;
    tick(1);
    sign_enable  = 1'b1;
    sign_timeout = v;
    tick(1);
    tick(17);
  endtask

  initial begin
    reset = 1'b1;
    sign_enable = 1'b0;
    sign_timeout = 32'd0;
    tick(2);
    chk("rst_an",   {28'd0, an},  32'hF);
    chk("rst_seg",  {25'd0, seg}, 32'h7F);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);

    // 1234: busy window T+1..T+15, digits at T+16
    reset = 1'b0;
    sign_enable = 1'b1;
    sign_timeout = 32'd1234;
    tick(1);
    chk("busy_T", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      chk("busy_win", {31'd0, busy}, 32'd1);
    end
    tick(1);
    chk("busy_T16", {31'd0, busy}, 32'd0);
    chk("ovf_1234", {31'd0, overflow}, 32'd0);
    tick(1);
    check_display("d1234", 16'h1234, 16);

    // display off retains state
    sign_enable = 1'b0;
    tick(2);
    chk("off_an",  {28'd0, an},  32'hF);
    chk("off_seg", {25'd0, seg}, 32'h7F);

    // saturation then clear
    capture(32'd70000);
    chk("ovf_sat", {31'd0, overflow}, 32'd1);
    check_display("d9999", 16'h9999, 16);
    capture(32'd5);
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    check_display("d0005", 16'h0005, 16);

    // re-trigger at T+5 is ignored
    sign_enable = 1'b0;
    tick(1);
    sign_enable  = 1'b1;
    sign_timeout = 32'd3810;
    tick(1);
    tick(3);
    sign_enable = 1'b0;
    tick(1);
    sign_enable  = 1'b1;
    sign_timeout = 32'd42;
    tick(1);
    tick(11);
    chk("retrig_busy", {31'd0, busy}, 32'd0);
    tick(1);
    check_display("d3810", 16'h3810, 20);
    chk("retrig_idle", {31'd0, busy}, 32'd0);

    // small value, leading digits
    capture(32'd7);
    check_display("d0007", 16'h0007, 16);

    // reset mid-conversion
    sign_enable = 1'b0;
    tick(1);
    sign_enable  = 1'b1;
    sign_timeout = 32'd9876;
    tick(1);
    tick(7);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_an",   {28'd0, an},  32'hF);
    chk("abort_seg",  {25'd0, seg}, 32'h7F);
    chk("abort_ovf",  {31'd0, overflow}, 32'd0);
    // enable already high after reset counts as a rising edge
    reset = 1'b0;
    tick(1);
    chk("post_rst_T", {31'd0, busy}, 32'd0);
    check_display("d0000", 16'h0000, 12);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    tick(4);
    chk("post_rst_done", {31'd0, busy}, 32'd0);
    tick(1);
    check_display("d9876", 16'h9876, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/timeout_display.md
TIMEOUT_DISPLAY -- requirements
Module: timeout_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each digit is driven during scanning (legal range 2 to 2^20).
REQ-002 Port clk SHALL be an input, 1 bit: the single rising-edge clock for all logic.
REQ-003 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port sign_enable SHALL be an input, 1 bit: high while the upstream timer FSM holds a result for display.
REQ-005 Port sign_timeout SHALL be an input, 32 bits: unsigned measured count from the upstream timer FSM.
REQ-006 Port seg SHALL be an output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-007 Port an SHALL be an output, 4 bits: active-low digit anodes; an[0] is the least significant digit.
REQ-008 Port busy SHALL be an output, 1 bit: high while a BCD conversion is in progress.
REQ-009 Port overflow SHALL be an output, 1 bit: high when the last captured value exceeded 9999.

Function
REQ-010 Capture: the rising edge of sign_enable SHALL be detected as "sampled 1 at edge T, sampled 0 at edge T-1", using a registered copy of sign_enable.
REQ-011 At detection edge T in state IDLE, the block SHALL latch sign_timeout, saturate values above 9999 to 9999, set overflow to 1 if saturated (else 0), and enter CONVERT.
REQ-012 A rising edge of sign_enable detected while not in IDLE SHALL be ignored and not queued.
REQ-013 The state machine SHALL have states IDLE, CONVERT and DONE.
  - IDLE to CONVERT on detection.
  - CONVERT performs a 14-bit shift-add-3 (double-dabble), one bit per cycle, for exactly 14 cycles.
  - CONVERT to DONE after the 14th bit.
  - DONE to IDLE unconditionally after one cycle.
REQ-014 busy SHALL be 1 from edge T+1 through edge T+15 inclusive, and 0 from edge T+16.
REQ-015 The four displayed BCD digit registers SHALL update together at edge T+16 and SHALL otherwise hold their value; intermediate conversion values SHALL never be displayed.
REQ-016 Scanning: a prescale counter SHALL count 0..SCAN_DIV-1 continuously; on wrap, the 2-bit digit index SHALL advance 0 to 1 to 2 to 3 to 0.
REQ-017 When sign_enable=1, the an bit for the current index SHALL be 0 and all other an bits 1, and seg SHALL carry that digit's pattern.
REQ-018 When sign_enable=0, an SHALL be 4'b1111 and seg SHALL be 7'b1111111; digit registers and overflow SHALL be retained.
REQ-019 Segment patterns SHALL be (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-020 seg and an SHALL be registered outputs and SHALL change only at clock edges.

Reset
REQ-021 At a clock edge with reset=1, the block SHALL force: state=IDLE; digits=0; overflow=0; busy=0; an=4'b1111; seg=7'b1111111; prescale counter=0; digit index=0; registered sign_enable=0.
REQ-022 Reset asserted during CONVERT SHALL abort the conversion and leave the digits at 0.
REQ-023 After reset, if sign_enable is already high, that SHALL count as a rising edge at the first non-reset edge.

Configuration
REQ-024 With macro LEADING_ZERO_BLANK_EN defined, digits above the most significant nonzero digit SHALL display blank; digit 0 SHALL always display, so the value 0 shows a single "0".
REQ-025 Without LEADING_ZERO_BLANK_EN, all four digits SHALL display, including leading zeros.

Verification (bench uses SCAN_DIV=4)
REQ-026 Reset, then pulse sign_enable high with sign_timeout=1234 -> busy high for edges T+1..T+15; digits 1,2,3,4 at T+16; overflow=0.
REQ-027 With sign_enable held high after REQ-026 -> an cycles 1110, 1101, 1011, 0111, each for 4 cycles; seg is 4, 3, 2, 1 respectively.
REQ-028 sign_timeout=32'd70000 -> digits 9,9,9,9 and overflow=1; a following capture of 5 -> overflow=0.
REQ-029 A second rising edge of sign_enable at T+5 with sign_timeout=42 -> ignored; digits stay at the first value.
REQ-030 sign_timeout=7, checked with LEADING_ZERO_BLANK_EN -> digits 3..1 show 1111111 and digit 0 shows 1111000; without the macro -> "0007".
REQ-031 Reset asserted at T+8 -> busy=0, digits 0, and an=1111 at the next edge.
